// File: rtl/md_unit_pkg.sv
// Shared op codes, FSM states and the divide helper for the EX-stage mult/div unit.
package md_unit_pkg;

    typedef enum logic [3:0] {
        MDOP_NONE  = 4'd0,
        MDOP_MULT  = 4'd1,
        MDOP_MULTU = 4'd2,
        MDOP_DIV   = 4'd3,
        MDOP_DIVU  = 4'd4,
        MDOP_MTHI  = 4'd5,
        MDOP_MTLO  = 4'd6
    } mdop_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

    // Returns {remainder, quotient}. Works on magnitudes so the signed
    // overflow case (-2^31 / -1) wraps to 0x80000000 with no special path.
    function automatic logic [63:0] md_divide(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic        sgn);
        logic [31:0] ma, mb, q, r;
        ma = (sgn && a[31]) ? (~a + 32'd1) : a;
        mb = (sgn && b[31]) ? (~b + 32'd1) : b;
        if (mb == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (sgn && (a[31] ^ b[31])) q = ~q + 32'd1;
        if (sgn && a[31])           r = ~r + 32'd1;
        return {r, q};
    endfunction

endpackage

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit: result is computed at issue, the counter only
// models latency so the hazard logic sees a realistic Busy window.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    md_state_e   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0] hi_tmp, lo_tmp, hi_tmp_n, lo_tmp_n, hi_n, lo_n;
    logic        keep, keep_n, busy_n;
    logic [63:0] prod, dres;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            hi_tmp <= '0;
            lo_tmp <= '0;
            keep   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
            Busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            hi_tmp <= hi_tmp_n;
            lo_tmp <= lo_tmp_n;
            keep   <= keep_n;
            HI     <= hi_n;
            LO     <= lo_n;
            Busy   <= busy_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        hi_tmp_n = hi_tmp;
        lo_tmp_n = lo_tmp;
        keep_n   = keep;
        hi_n     = HI;
        lo_n     = LO;
        busy_n   = Busy;
        prod     = '0;
        dres     = '0;
        case (state)
            S_IDLE: begin
                case (MDOp)
                    MDOP_MULT, MDOP_MULTU: begin
                        if (MDOp == MDOP_MULT)
                            prod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
                        else
                            prod = {32'd0, A} * {32'd0, B};
                        hi_tmp_n = prod[63:32];
                        lo_tmp_n = prod[31:0];
                        keep_n   = 1'b0;
                        cnt_n    = CW'(MULT_CYCLES);
                        busy_n   = 1'b1;
                        state_n  = S_RUN;
                    end
                    MDOP_DIV, MDOP_DIVU: begin
                        dres     = md_divide(A, B, MDOp == MDOP_DIV);
                        hi_tmp_n = dres[63:32];
                        lo_tmp_n = dres[31:0];
                        keep_n   = (B == 32'd0);
                        cnt_n    = CW'(DIV_CYCLES);
                        busy_n   = 1'b1;
                        state_n  = S_RUN;
                    end
                    MDOP_MTHI: hi_n = A;
                    MDOP_MTLO: lo_n = A;
                    default: ;
                endcase
            end
            S_RUN: begin
                // MDOp and operands are deliberately ignored here.
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    if (!keep) begin
                        hi_n = hi_tmp;
                        lo_n = lo_tmp;
                    end
                    busy_n  = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes per-cycle HI/LO/Busy
// expectations from an arithmetic model; a negedge monitor pops and checks.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MDOp;
    logic [31:0] A, B;
    logic [31:0] HI, LO;
    logic        Busy;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .MDOp(MDOp), .A(A), .B(B),
        .HI(HI), .LO(LO), .Busy(Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    exp_t        expq[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_hi = 0, m_lo = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (expq.size() > 0 && expq[0].cyc <= cyc) begin
            exp_t e;
            e = expq.pop_front();
            n_chk++;
            if (e.cyc != cyc || Busy !== e.busy || HI !== e.hi || LO !== e.lo) begin
                n_fail++;
                $display("FAIL %s cyc=%0d(exp %0d): got busy=%0b hi=%h lo=%h, expected busy=%0b hi=%h lo=%h",
                         e.name, cyc, e.cyc, Busy, HI, LO, e.busy, e.hi, e.lo);
            end
        end
    end

    function automatic void push(int c, logic bz, logic [31:0] h, logic [31:0] l, string nm);
        exp_t e;
        e.cyc = c; e.busy = bz; e.hi = h; e.lo = l; e.name = nm;
        expq.push_back(e);
    endfunction

    // Called just after a rising edge; issues op in the current cycle.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string nm, input int abort);
        int          t, n, lim;
        logic        start, keep;
        logic [31:0] nh, nl;
        longint      sa, sb, sq, sr;
        longint unsigned ua, ub, up;
        t = cyc;
        MDOp = op; A = a; B = b;
        start = 1'b0; keep = 1'b0; n = 0;
        nh = m_hi; nl = m_lo;
        case (op)
            4'd1: begin
                sa = $signed(a); sb = $signed(b); sq = sa * sb;
                nh = sq[63:32]; nl = sq[31:0]; start = 1'b1; n = MC;
            end
            4'd2: begin
                ua = a; ub = b; up = ua * ub;
                nh = up[63:32]; nl = up[31:0]; start = 1'b1; n = MC;
            end
            4'd3, 4'd4: begin
                start = 1'b1; n = DC;
                if (b == 0) keep = 1'b1;
                else if (op == 4'd3) begin
                    sa = $signed(a); sb = $signed(b);
                    sq = sa / sb; sr = sa % sb;
                    nl = sq[31:0]; nh = sr[31:0];
                end else begin
                    nl = a / b; nh = a % b;
                end
            end
            4'd5: nh = a;
            4'd6: nl = a;
            default: ;
        endcase
        if (start) begin
            lim = (abort > 0) ? abort : n;
            for (int k = 1; k <= lim; k++) push(t + k, 1'b1, m_hi, m_lo, {nm, "_busy"});
            for (int k = 1; k <= lim; k++) begin
                @(posedge clk); #1;
                if (abort > 0 && k == abort) begin
                    reset = 1'b1; MDOp = 4'd0;
                end else begin
                    MDOp = (k == 1) ? 4'd6 : 4'($urandom_range(0, 15));
                    A = (k == 1) ? 32'hDEAD : $urandom;
                    B = $urandom;
                end
            end
            @(posedge clk); #1;
            if (abort > 0) begin
                reset = 1'b0;
                m_hi = 0; m_lo = 0;
            end else if (!keep) begin
                m_hi = nh; m_lo = nl;
            end
            push(t + lim + 1, 1'b0, m_hi, m_lo, {nm, "_done"});
        end else begin
            m_hi = nh; m_lo = nl;
            push(t + 1, 1'b0, m_hi, m_lo, nm);
            @(posedge clk); #1;
        end
        MDOp = 4'd0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int w;
        reset = 1'b1; MDOp = 4'd0; A = 0; B = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        push(cyc, 1'b0, 32'h0, 32'h0, "reset_state");

        do_op(4'd5, 32'h1234, 0, "pre_mthi", 0);
        do_op(4'd3, 32'd100, 32'd7, "rst_mid", 3);
        do_op(4'd5, 32'd5, 0, "mthi_after_rst", 0);
        do_op(4'd1, 32'hFFFF_FFFE, 32'd3, "mult_neg", 0);
        do_op(4'd2, 32'hFFFF_FFFE, 32'd3, "multu", 0);
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2, "div_neg", 0);
        do_op(4'd4, 32'd7, 32'd2, "divu", 0);
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0);
        do_op(4'd5, 32'h11, 0, "mthi11", 0);
        do_op(4'd6, 32'h22, 0, "mtlo22", 0);
        do_op(4'd3, 32'd55, 32'd0, "div_zero", 0);
        do_op(4'd4, 32'd55, 32'd0, "divu_zero", 0);
        do_op(4'd1, 32'd12345, 32'hFFFF_0000, "mult_b2b", 0);
        do_op(4'd9, 32'h77, 32'h88, "op_undef", 0);

        for (int i = 0; i < 40; i++)
            do_op(4'($urandom_range(0, 8)), pick_operand(), pick_operand(), "rand", 0);

        w = 0;
        while (expq.size() > 0 && w < 50) begin
            @(posedge clk);
            w++;
        end
        @(posedge clk);
        if (expq.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
